alu_srcb_stage: RTL

ALU_SRCB_STAGE -- requirements
Module: alu_srcb_stage

---
 rtl/alu_srcb_pkg.sv | 26 ++
 rtl/alu_srcb_buf.sv | 75 +++++++
 rtl/alu_srcb_stage.sv | 76 +++++++
 3 files changed

// File: rtl/alu_srcb_pkg.sv
// Shared selector codes and enum for the ALU B-source stage.
package alu_srcb_pkg;

    localparam logic [2:0] SRCB_BOUT     = 3'b000;
    localparam logic [2:0] SRCB_INC      = 3'b001;
    localparam logic [2:0] SRCB_SEXT     = 3'b010;
    localparam logic [2:0] SRCB_SEXT_SHL = 3'b011;
    localparam logic [2:0] SRCB_ZEXT     = 3'b100;
    localparam logic [2:0] SRCB_LUI      = 3'b101;

    typedef enum logic [2:0] {
        SEL_BOUT     = SRCB_BOUT,
        SEL_INC      = SRCB_INC,
        SEL_SEXT     = SRCB_SEXT,
        SEL_SEXT_SHL = SRCB_SEXT_SHL,
        SEL_ZEXT     = SRCB_ZEXT,
        SEL_LUI      = SRCB_LUI,
        SEL_ILL6     = 3'b110,
        SEL_ILL7     = 3'b111
    } srcb_sel_e;

    function automatic logic sel_is_illegal(input logic [2:0] sel);
        return (sel > SRCB_LUI);
    endfunction

endpackage

// File: rtl/alu_srcb_buf.sv
// Operand storage and valid/ready handshake for the B-source stage.
// With ALU_SRCB_SKID_EN defined a skid entry decouples in_ready from out_ready.
module alu_srcb_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;

`ifdef ALU_SRCB_SKID_EN
    logic              skid_valid_r;
    logic [DATA_W-1:0] skid_data_r;
    logic              in_fire_s;
    logic              out_free_s;

    assign in_ready   = !skid_valid_r;
    assign in_fire_s  = in_valid && !skid_valid_r;
    assign out_free_s = !out_valid_r || out_ready;

    // Output slot refills from skid first (ordering), otherwise from input; stalled input lands in skid.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= '0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
        end else if (out_free_s) begin
            if (skid_valid_r) begin
                out_data_r   <= skid_data_r;
                out_valid_r  <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (in_fire_s) begin
                out_data_r  <= in_data;
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= 1'b0;
            end
        end else if (in_fire_s) begin
            skid_data_r  <= in_data;
            skid_valid_r <= 1'b1;
        end
    end
`else
    logic in_fire_s;

    assign in_ready  = !out_valid_r || out_ready;
    assign in_fire_s = in_valid && in_ready;

    // Single-entry pipeline register; a new operand overwrites the one leaving this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (in_fire_s) begin
            out_data_r  <= in_data;
            out_valid_r <= 1'b1;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end
`endif

endmodule

// File: rtl/alu_srcb_stage.sv
// ALU B-operand source select stage: decode selector, register operand, flag illegal codes.
// Optional skid entry enabled by defining ALU_SRCB_SKID_EN.
module alu_srcb_stage
    import alu_srcb_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int unsigned INC_CONST = 4,
    parameter int unsigned SHIFT_AMT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        selector,
    input  logic [DATA_W-1:0] b_out,
    input  logic [DATA_W-1:0] sign_ext,
    input  logic [15:0]       imm16,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              sel_err,
    input  logic              err_clear
);

    localparam logic [DATA_W-1:0] INC_VAL = DATA_W'(INC_CONST);

    srcb_sel_e         sel_s;
    logic [DATA_W-1:0] zext_s;
    logic [DATA_W-1:0] operand_s;
    logic              accept_s;
    logic              sel_err_r;

    assign sel_s    = srcb_sel_e'(selector);
    assign zext_s   = DATA_W'(imm16);
    assign accept_s = in_valid && in_ready;
    assign sel_err  = sel_err_r;

    // Operand decode; illegal selectors deliver zero.
    always_comb begin
        operand_s = '0;
        case (sel_s)
            SEL_BOUT:     operand_s = b_out;
            SEL_INC:      operand_s = INC_VAL;
            SEL_SEXT:     operand_s = sign_ext;
            SEL_SEXT_SHL: operand_s = sign_ext << SHIFT_AMT;
            SEL_ZEXT:     operand_s = zext_s;
            SEL_LUI:      operand_s = zext_s << 5'd16;
            default:      operand_s = '0;
        endcase
    end

    // Sticky illegal-selector flag; a new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel_err_r <= 1'b0;
        end else if (accept_s && sel_is_illegal(selector)) begin
            sel_err_r <= 1'b1;
        end else if (err_clear) begin
            sel_err_r <= 1'b0;
        end
    end

    alu_srcb_buf #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (operand_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (data_out)
    );

endmodule
